dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder-side data memory for the pipelined RISC-V core's load/store path.
- Replaces the combinational single-cycle DataMemory model with a valid/ready request/response target with configurable latency.
- Accepts one word-access request at a time, models fixed access latency, commits writes with byte strobes, and holds each response until the initiator accepts it.
- Sits between the MEM stage (or a future MEM-stage stall controller) and the word-addressed storage array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 4: cycles from the request-accept edge to the first cycle resp_valid is high; legal range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_wstrb  input  4  byte enables for stores; bit i enables byte lane i; ignored for loads
- resp_valid  output  1  response available
- resp_ready  input  1  initiator accepts the response
- resp_rdata  output  32  word contents after commit
- resp_write  output  1  echo of the accepted req_write
- resp_err  output  1  error flag; see Optional Feature
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: synchronous, active-high; clock clk. On reset, state goes to IDLE and all of the following clear to 0: resp_valid, resp_rdata, resp_write, resp_err, busy, latency counter, latched request. req_ready is 1 in the cycle after reset deasserts. Array contents are not cleared by reset.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- State IDLE:
  - req_ready = 1.
  - On the edge where req_valid & req_ready is true: latch write, addr, wdata and wstrb.
  - If LATENCY == 1, go to RESP; otherwise load counter = LATENCY-1 and go to WAIT.
- State WAIT:
  - req_ready = 0; request inputs are ignored.
  - Counter decrements by 1 each cycle.
  - Move to RESP on the edge where counter == 1.
- Commit on the edge that enters RESP:
  - Store: each byte lane i with wstrb[i] = 1 is written into the array word.
  - resp_rdata captures the word value after the merge, for both loads and stores.
  - resp_write captures the latched write bit.
- Latency: resp_valid rises exactly LATENCY cycles after the accept edge.
- State RESP:
  - resp_valid = 1.
  - resp_rdata, resp_write and resp_err stay stable until the edge where resp_valid & resp_ready is true.
- Response handshake edge:
  - With no new request, go to IDLE and clear resp_valid.
  - req_ready = (state == IDLE) | (state == RESP & resp_ready).
  - Back-to-back: a request presented in the same cycle as the response handshake is accepted on that edge. The next state is then WAIT, or RESP again when LATENCY == 1, so resp_valid stays high and carries the new data.
- Ordering: requests complete strictly in order, with one outstanding request at most. A load issued after a store to the same word returns the stored data.
- Reset mid-operation: a pending request is dropped. A store that has not yet reached its commit edge is not written. The array keeps previously committed data.
- A store with wstrb = 0000 leaves the array unchanged and still returns a response, with rdata equal to the current word.

Optional Feature:
- Macro: DMEM_ERR_EN.
- With the macro defined, resp_err = 1 when either:
  - req_addr[1:0] != 0, or
  - req_addr[31:2] >= DEPTH_WORDS.
- An errored request is not committed, resp_rdata = 0, and latency and handshake timing are unchanged.
- Without the macro:
  - resp_err is tied to 0.
  - req_addr[1:0] is ignored.
  - Address bits above the index are ignored, so accesses wrap modulo DEPTH_WORDS*4.

Test Plan:
1. Reset, then a load at any address; LATENCY=4 -> req_ready=1 on the first post-reset cycle; resp_valid rises exactly 4 cycles after the accept edge; busy=1 during WAIT.
2. Store addr 0x10, wdata 0xDEADBEEF, wstrb 1111; then load 0x10 -> store response rdata=0xDEADBEEF, resp_write=1; load rdata=0xDEADBEEF, resp_write=0.
3. Store 0x10 wstrb 0010 wdata 0x0000AA00 over 0xDEADBEEF -> rdata=0xDEADAAEF; a subsequent store with wstrb 0000 -> rdata=0xDEADAAEF and array unchanged.
4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable and req_ready=0; raise resp_ready together with req_valid -> new request accepted on that same edge, with LATENCY=1 giving a continuous resp_valid.
5. Assert reset during WAIT of a store to 0x20 wdata 0x12345678 -> next response IDLE, no response; a later load from 0x20 returns the prior value.
6. DMEM_ERR_EN defined: store to 0x22, then a load at 4*DEPTH_WORDS -> resp_err=1 and rdata=0 for both, no write committed. Macro undefined: load at 4*DEPTH_WORDS returns word 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder_if                                                |
// | Valid/ready request/response bundle between MEM stage and dmem.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_write;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder                                                   |
// | Fixed-latency valid/ready data memory; byte-strobed stores.      |
// | Optional macro DMEM_ERR_EN: flag misaligned/out-of-range access. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  wire              clk,
  input  wire              reset,
  dmem_responder_if.slave  bus,
  output logic             busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_write_q, lat_write_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_wstrb_q, lat_wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_write_q, resp_write_d;
  logic        resp_err_q, resp_err_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             req_ready_w;
  logic             accept;
  logic             commit;
  logic             mem_we;
  logic             com_write;
  logic [31:0]      com_addr;
  logic [31:0]      com_wdata;
  logic [3:0]       com_strb;
  logic [IDX_W-1:0] com_idx;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic             err;

  assign req_ready_w = (state_q == ST_IDLE) || (state_q == ST_RESP && bus.resp_ready);
  assign accept      = bus.req_valid && req_ready_w;

  // From WAIT the commit uses the latched request; otherwise (LATENCY == 1)
  // the commit coincides with the accept edge and uses the live inputs.
  assign com_write = (state_q == ST_WAIT) ? lat_write_q : bus.req_write;
  assign com_addr  = (state_q == ST_WAIT) ? lat_addr_q  : bus.req_addr;
  assign com_wdata = (state_q == ST_WAIT) ? lat_wdata_q : bus.req_wdata;
  assign com_strb  = com_write ? ((state_q == ST_WAIT) ? lat_wstrb_q : bus.req_wstrb) : 4'b0000;
  assign com_idx   = com_addr[IDX_W+1:2];
  assign cur_word  = mem[com_idx];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = com_strb[i] ? com_wdata[8*i +: 8] : cur_word[8*i +: 8];
  end

`ifdef DMEM_ERR_EN
  assign err = (com_addr[1:0] != 2'b00) || ({2'b00, com_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr;
  assign unused_addr = ^{com_addr[31:IDX_W+2], com_addr[1:0]};
  assign err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_wstrb_d  = lat_wstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_write_d = resp_write_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;

    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) commit = 1'b1;
    end

    if (state_q == ST_RESP && bus.resp_ready) begin
      resp_valid_d = 1'b0;
      state_d      = ST_IDLE;
    end

    if (accept) begin
      lat_write_d = bus.req_write;
      lat_addr_d  = bus.req_addr;
      lat_wdata_d = bus.req_wdata;
      lat_wstrb_d = bus.req_wstrb;
      if (LATENCY == 1) begin
        commit = 1'b1;
      end else begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = ST_WAIT;
      end
    end

    if (commit) begin
      state_d      = ST_RESP;
      resp_valid_d = 1'b1;
      resp_rdata_d = err ? 32'h0 : merged;
      resp_write_d = com_write;
      resp_err_d   = err;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // A store caught by reset before its commit edge must never reach the array.
  assign mem_we = commit && com_write && !err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[com_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      lat_wstrb_q  <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_write_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_wstrb_q  <= lat_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_write_q <= resp_write_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_write = resp_write_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = busy_q;
endmodule
`default_nettype wire
